// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg -- shared types and constant helpers for the gated frequency meter.
//   state_t         : measurement FSM states (IDLE, GATE, CAPTURE)
//   gate_cycles()   : gate window length in system clock cycles
//   gate_cnt_width(): width of the gate-window counter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GATE    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Number of system clock cycles in one gate window.
  function automatic int gate_cycles(input int clk_hz, input int gate_div);
    return clk_hz / gate_div;
  endfunction

  // Gate counter only has to reach gate_cycles-2, so clog2 of the window is enough.
  function automatic int gate_cnt_width(input int n_cycles);
    return (n_cycles <= 2) ? 1 : $clog2(n_cycles);
  endfunction

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// sig_sync_edge -- conditions the measured signal and produces a one-cycle
// pulse on each 0->1 transition.
// Build option: FREQ_METER_SYNC_EN
//   defined     : i_sig goes through a 2-FF synchronizer first (edge latency 3)
//   not defined : i_sig must already be synchronous to i_clk (edge latency 1)
// Ports:
//   i_clk   in  system clock
//   i_rst_n in  asynchronous active-low reset
//   i_sig   in  measured signal
//   o_edge  out rising-edge pulse, one cycle wide
module sig_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic w_cond;
  logic r_dly;

`ifdef FREQ_METER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-stage synchronizer for an input asynchronous to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cond = r_sync2;
`else
  assign w_cond = i_sig;
`endif

  // One-cycle delayed copy of the conditioned signal for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dly <= 1'b0;
    end else begin
      r_dly <= w_cond;
    end
  end

  assign o_edge = w_cond & ~r_dly;

endmodule

// File: rtl/freq_meter.sv
// freq_meter -- gated frequency counter. Counts rising edges of SIG_IN over
// back-to-back windows of CLK_HZ/GATE_DIV system clock cycles and publishes
// each window's count through a valid/ack result register.
// Build option: FREQ_METER_SYNC_EN (see sig_sync_edge) adds a 2-FF input
// synchronizer for an SIG_IN that is asynchronous to CLK.
// Ports:
//   CLK          in   system clock, all logic on posedge
//   RST_N        in   asynchronous active-low reset
//   SIG_IN       in   measured signal
//   MEAS_EN      in   level, high runs back-to-back windows
//   RESULT_ACK   in   consumer acknowledges the current result
//   FREQ_COUNT   out  rising edges counted in the last completed window
//   RESULT_VALID out  result held, level until acknowledged
//   SAT          out  FREQ_COUNT saturated in that window
//   OVERRUN      out  sticky, an unacknowledged result was overwritten
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int GATE_DIV  = 10,
  parameter int CNT_WIDTH = 24
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SIG_IN,
  input  logic                 MEAS_EN,
  input  logic                 RESULT_ACK,
  output logic [CNT_WIDTH-1:0] FREQ_COUNT,
  output logic                 RESULT_VALID,
  output logic                 SAT,
  output logic                 OVERRUN
);

  localparam int GATE_CYCLES = gate_cycles(CLK_HZ, GATE_DIV);
  localparam int GW          = gate_cnt_width(GATE_CYCLES);
  // GATE spans counts 0..GATE_CYCLES-2, CAPTURE adds one cycle: full window.
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 2);

  state_t                 r_state;
  state_t                 w_next;
  logic [GW-1:0]          r_gate_cnt;
  logic [CNT_WIDTH-1:0]   r_edge_cnt;
  logic                   r_sat;
  logic [CNT_WIDTH-1:0]   r_freq_count;
  logic                   r_valid;
  logic                   r_sat_out;
  logic                   r_overrun;
  logic                   w_edge;

  sig_sync_edge u_edge (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_sig   (SIG_IN),
    .o_edge  (w_edge)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic; dropping MEAS_EN mid-window discards the window.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (MEAS_EN) w_next = ST_GATE;
        else         w_next = ST_IDLE;
      end
      ST_GATE: begin
        if (!MEAS_EN)                     w_next = ST_IDLE;
        else if (r_gate_cnt == GATE_LAST) w_next = ST_CAPTURE;
        else                              w_next = ST_GATE;
      end
      ST_CAPTURE: begin
        if (MEAS_EN) w_next = ST_GATE;
        else         w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Gate counter, saturating edge counter and its sat flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      case (r_state)
        ST_GATE: begin
          r_gate_cnt <= r_gate_cnt + GW'(1);
          if (w_edge) begin
            if (r_edge_cnt == {CNT_WIDTH{1'b1}}) r_sat <= 1'b1;
            else                                 r_edge_cnt <= r_edge_cnt + CNT_WIDTH'(1);
          end
        end
        ST_CAPTURE: begin
          // An edge in the capture cycle opens the next window's count.
          r_gate_cnt <= '0;
          r_edge_cnt <= w_edge ? CNT_WIDTH'(1) : CNT_WIDTH'(0);
          r_sat      <= 1'b0;
        end
        default: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
        end
      endcase
    end
  end

  // Result register and valid/ack handshake; capture takes priority over ack.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_freq_count <= '0;
      r_valid      <= 1'b0;
      r_sat_out    <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_state == ST_CAPTURE) begin
      r_freq_count <= r_edge_cnt;
      r_sat_out    <= r_sat;
      r_valid      <= 1'b1;
      if (r_valid && !RESULT_ACK) r_overrun <= 1'b1;
    end else if (RESULT_ACK && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign FREQ_COUNT   = r_freq_count;
  assign RESULT_VALID = r_valid;
  assign SAT          = r_sat_out;
  assign OVERRUN      = r_overrun;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with CLK_HZ=1000, GATE_DIV=10 (100-cycle windows).
// A second instance with CNT_WIDTH=4 shares all inputs to exercise saturation.
module tb_freq_meter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SIG_IN;
  logic        MEAS_EN;
  logic        RESULT_ACK;
  logic [23:0] fc;
  logic        rv, sat, ovr;
  logic [3:0]  fc4;
  logic        rv4, sat4, ovr4;

  int n_pass  = 0;
  int n_total = 0;
  int mode;        // 0: SIG_IN = lvl, 1: square wave
  logic lvl;
  int period;
  int ph;
  int cyc;

  always #5 CLK = ~CLK;

  freq_meter #(.CLK_HZ(1000), .GATE_DIV(10), .CNT_WIDTH(24)) dut (
    .CLK(CLK), .RST_N(RST_N), .SIG_IN(SIG_IN), .MEAS_EN(MEAS_EN),
    .RESULT_ACK(RESULT_ACK), .FREQ_COUNT(fc), .RESULT_VALID(rv),
    .SAT(sat), .OVERRUN(ovr)
  );

  freq_meter #(.CLK_HZ(1000), .GATE_DIV(10), .CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .SIG_IN(SIG_IN), .MEAS_EN(MEAS_EN),
    .RESULT_ACK(RESULT_ACK), .FREQ_COUNT(fc4), .RESULT_VALID(rv4),
    .SAT(sat4), .OVERRUN(ovr4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive SIG_IN for the coming cycle, then advance to just after the next posedge.
  task automatic step();
    if (mode == 1) begin
      SIG_IN = (ph < period / 2);
      ph = (ph + 1 == period) ? 0 : ph + 1;
    end else begin
      SIG_IN = lvl;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      step();
      n++;
      if (rv === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic ack_cycle();
    RESULT_ACK = 1'b1;
    step();
    RESULT_ACK = 1'b0;
  endtask

  // Return to IDLE with SIG_IN low, then enable with a fresh square wave.
  task automatic start(input int p, input int ph0);
    MEAS_EN    = 1'b0;
    mode       = 0;
    lvl        = 1'b0;
    RESULT_ACK = 1'b1;
    repeat (3) step();
    RESULT_ACK = 1'b0;
    mode    = 1;
    period  = p;
    ph      = ph0;
    MEAS_EN = 1'b1;
  endtask

  initial begin
    int n;
    bit ok;
    bit saw;
    RST_N = 1'b0; SIG_IN = 1'b0; MEAS_EN = 1'b0; RESULT_ACK = 1'b0;
    mode = 0; lvl = 1'b0; period = 10; ph = 0; cyc = 0;
    repeat (3) step();
    check("rst_count", fc, 0);
    check("rst_valid", rv, 0);
    check("rst_sat", sat, 0);
    check("rst_overrun", ovr, 0);
    check("rst_overrun_w4", ovr4, 0);
    check("rst_valid_w4", rv4, 0);
    RST_N = 1'b1;
    repeat (2) step();

    // 1: period-10 square wave, 10 edges every 100-cycle window
    mode = 1; period = 10; ph = 9; MEAS_EN = 1'b1;
    wait_valid(n, ok);
    check("t1_first_ok", ok, 1);
    check("t1_latency", n, 101);
    check("t1_count", fc, 10);
    check("t1_sat", sat, 0);
    for (int w = 0; w < 3; w++) begin
      ack_cycle();
      check("t1_ack_clears", rv, 0);
      wait_valid(n, ok);
      check("t1_interval", n + 1, 100);
      check("t1_count_n", fc, 10);
      check("t1_sat_n", sat, 0);
    end

    // 2: held low gives 0, one 0->1 step gives 1, held high gives 0
    mode = 0; lvl = 1'b0;
    ack_cycle();
    wait_valid(n, ok);
    check("t2_low", fc, 0);
    ack_cycle();
    repeat (49) step();
    lvl = 1'b1;
    wait_valid(n, ok);
    check("t2_step", fc, 1);
    ack_cycle();
    wait_valid(n, ok);
    check("t2_high", fc, 0);

    // 3: 25 edges saturate the 4-bit instance; next window at period 10 does not
    start(4, 3);
    wait_valid(n, ok);
    check("t3_count24", fc, 25);
    check("t3_sat24", sat, 0);
    check("t3_count4", fc4, 15);
    check("t3_sat4", sat4, 1);
    period = 10; ph = 0;
    ack_cycle();
    wait_valid(n, ok);
    check("t3_count4_after", fc4, 10);
    check("t3_sat4_after", sat4, 0);
    check("t3_count24_after", fc, 10);

    // 4: overrun after an unacked window, cleared by ack; ack on capture keeps it 0
    start(10, 9);
    wait_valid(n, ok);
    check("t4_first", fc, 10);
    check("t4_no_overrun", ovr, 0);
    period = 5; ph = 0;
    repeat (100) step();
    check("t4_overrun", ovr, 1);
    check("t4_valid_held", rv, 1);
    check("t4_second_count", fc, 20);
    ack_cycle();
    check("t4_ack_valid", rv, 0);
    check("t4_ack_overrun", ovr, 0);
    wait_valid(n, ok);
    check("t4_third", fc, 20);
    repeat (99) step();
    ack_cycle();
    check("t4_coinc_valid", rv, 1);
    check("t4_coinc_overrun", ovr, 0);
    check("t4_coinc_count", fc, 20);

    // 5: async reset mid-window clears outputs at once; restart latency 101
    repeat (50) step();
    RST_N = 1'b0;
    #1;
    check("t5_count", fc, 0);
    check("t5_valid", rv, 0);
    check("t5_overrun", ovr, 0);
    check("t5_sat", sat, 0);
    repeat (2) step();
    RST_N = 1'b1; mode = 1; period = 10; ph = 9;
    wait_valid(n, ok);
    check("t5_latency", n, 101);
    check("t5_count_after", fc, 10);

    // 6: MEAS_EN dropped mid-window yields no result
    ack_cycle();
    repeat (59) step();
    MEAS_EN = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (rv !== 1'b0) saw = 1'b1;
    end
    check("t6_no_result", saw, 0);

    // 6: edge in the capture cycle carries into the next window
    MEAS_EN = 1'b1; period = 10; ph = 0;
    wait_valid(n, ok);
    check("t6_first", fc, 9);
    ack_cycle();
    wait_valid(n, ok);
    check("t6_carry", fc, 10);
    ack_cycle();
    wait_valid(n, ok);
    check("t6_carry2", fc, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter for the iCE40 boards. It counts rising edges of an external or looped-back signal, such as the board test output, over a fixed gate window derived from the 100 MHz system clock. It publishes each window's count through a valid/ack result register. It is the measuring end paired with the test-signal generators in the board top levels, and it sits beside them on `CLK`.

## Interface
- `CLK_HZ`, 100000000: system clock frequency in Hz.
- `GATE_DIV`, 10: gate window is `CLK_HZ/GATE_DIV` cycles (`GATE_CYCLES`); default 10,000,000 cycles = 100 ms.
- `CNT_WIDTH`, 24: edge-count and result width.
- `CLK`  in  1  system clock; all logic on posedge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `SIG_IN`  in  1  measured signal; asynchronous to `CLK` when `FREQ_METER_SYNC_EN` is defined.
- `MEAS_EN`  in  1  level; high = run back-to-back windows.
- `RESULT_ACK`  in  1  consumer acknowledges the current result.
- `FREQ_COUNT`  out  `CNT_WIDTH`  rising edges in the last completed window.
- `RESULT_VALID`  out  1  result held; level until acked.
- `SAT`  out  1  `FREQ_COUNT` saturated in that window.
- `OVERRUN`  out  1  sticky; an unacked result was overwritten.

## Operation
- Reset (async, `RST_N`=0): state IDLE, all counters 0, `FREQ_COUNT`=0, `RESULT_VALID`=0, `SAT`=0, `OVERRUN`=0.
- Edge detect: the conditioned signal is compared with its one-cycle-delayed copy; 0→1 gives a one-cycle `edge` pulse.
- FSM states:
  - IDLE: counters held at 0. `MEAS_EN`=1 → GATE.
  - GATE: gate counter increments each cycle. The edge counter increments on `edge` and saturates at all-ones, setting an internal sat bit. At gate counter = `GATE_CYCLES`-2 → CAPTURE. `MEAS_EN`=0 → IDLE; the partial window is discarded and no result is produced.
  - CAPTURE: one cycle.
    - Load `FREQ_COUNT` with the edge counter and `SAT` with the sat bit.
    - Set `RESULT_VALID`.
    - Clear the gate counter.
    - Load the edge counter with 1 if `edge` fires this cycle, else 0, so no edge is lost.
    - Clear the sat bit.
    - Go to GATE if `MEAS_EN`=1, else IDLE.
- Window period GATE→CAPTURE→GATE is exactly `GATE_CYCLES` cycles.
- Result handshake:
  - `RESULT_ACK`=1 with `RESULT_VALID`=1 clears `RESULT_VALID` next cycle.
  - `RESULT_ACK` while not valid is ignored.
  - CAPTURE while `RESULT_VALID`=1 and no ack that cycle sets `OVERRUN`; the new result replaces the old.
  - CAPTURE and `RESULT_ACK` in the same cycle: the new result loads, `RESULT_VALID` stays 1, `OVERRUN` unchanged.
  - `OVERRUN` clears only on reset or on `RESULT_ACK` while `RESULT_VALID`=1.
- `FREQ_COUNT`/`SAT` are stable while `RESULT_VALID`=1 unless overwritten by the next CAPTURE.
- Width rule: `GATE_CYCLES` ≥ 4. The gate counter is `$clog2(GATE_CYCLES)` bits. Edges per window never exceed `GATE_CYCLES/2`, so saturation occurs only when `CNT_WIDTH` is undersized.

## Timing
- `SIG_IN` 0→1 to `edge` pulse: 3 cycles with the synchronizer, 1 without.
- CAPTURE at cycle N gives `RESULT_VALID`/`FREQ_COUNT` visible at N+1.
- `MEAS_EN` rise to first `RESULT_VALID`: `GATE_CYCLES`+1 cycles.
- Maximum countable rate: `CLK_HZ/2` (signal high ≥1 cycle and low ≥1 cycle after conditioning).

## Configuration
- `FREQ_METER_SYNC_EN` defined: `SIG_IN` passes through a 2-FF synchronizer before edge detect; edge latency 3 cycles.
- Not defined: `SIG_IN` must be synchronous to `CLK` (for example, a divided counter bit); it feeds edge detect directly; edge latency 1 cycle.

## Structure
- `freq_meter_pkg`:
  - state enum (IDLE, GATE, CAPTURE);
  - function computing `GATE_CYCLES` from `CLK_HZ`, `GATE_DIV`;
  - gate-counter width helper.
- Sub-module `sig_sync_edge`: optional 2-FF synchronizer under `FREQ_METER_SYNC_EN`, delay register, rising-edge pulse output.
- `freq_meter`: FSM, gate counter, saturating edge counter, result/handshake registers.

## Test plan
Bench parameters: `CLK_HZ`=1000, `GATE_DIV`=10, so `GATE_CYCLES`=100.

1. `SIG_IN` synchronous square wave, period 10 cycles, `MEAS_EN`=1, ack each result → every window `FREQ_COUNT`=10, `SAT`=0, a result every 100 cycles.
2. `SIG_IN` held 0, then held 1 → `FREQ_COUNT`=0; the single 0→1 step gives exactly 1 in its window.
3. `CNT_WIDTH`=4, `SIG_IN` period 4 (25 edges) → `FREQ_COUNT`=15, `SAT`=1; the next window at period 10 gives 10, `SAT`=0.
4. No `RESULT_ACK` for two windows → `OVERRUN`=1, `FREQ_COUNT` = second window's count; ack → `RESULT_VALID`=0 and `OVERRUN`=0 next cycle. Ack coincident with CAPTURE → `OVERRUN` stays 0.
5. `RST_N` pulsed low at cycle 50 of a window → all outputs 0 immediately, FSM IDLE; after release, first result 101 cycles after `MEAS_EN` is seen high.
6. `MEAS_EN` dropped at cycle 60 → no `RESULT_VALID`. Edge coincident with CAPTURE → counted in the following window (10 per window preserved with a phase-aligned period-10 input).
